// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder_pkg : shared widths, access sizes and FSM states     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package dmem_responder_pkg;

   localparam int WORD_SIZE = 32;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_INV = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_ctrl : little-endian byte-lane steering for dmem_responder|
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module dmem_lane_ctrl
   import dmem_responder_pkg::*;
(
   input  logic [1:0]           i_addr_lo,
   input  logic [1:0]           i_size,
   input  logic [WORD_SIZE-1:0] i_wdata,
   input  logic [WORD_SIZE-1:0] i_rword,
   output logic [3:0]           o_be,
   output logic [WORD_SIZE-1:0] o_wdata_sh,
   output logic [WORD_SIZE-1:0] o_rdata,
   output logic                 o_misalign
);

   logic [1:0]           w_lane;
   logic [4:0]           w_shamt;
   logic [WORD_SIZE-1:0] w_mask;

   // Lane offsets are always aligned down; the top decides whether misalignment faults.
   always_comb begin
      w_lane     = 2'b00;
      o_be       = 4'b0000;
      w_mask     = '0;
      o_misalign = 1'b0;
      case (i_size)
         SIZE_B: begin
            w_lane = i_addr_lo;
            o_be   = 4'b0001 << i_addr_lo;
            w_mask = 32'h0000_00FF;
         end
         SIZE_H: begin
            w_lane     = {i_addr_lo[1], 1'b0};
            o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
            w_mask     = 32'h0000_FFFF;
            o_misalign = i_addr_lo[0];
         end
         SIZE_W: begin
            o_be       = 4'b1111;
            w_mask     = 32'hFFFF_FFFF;
            o_misalign = |i_addr_lo;
         end
         default: ;
      endcase
   end

   assign w_shamt    = {w_lane, 3'b000};
   assign o_wdata_sh = i_wdata << w_shamt;
   assign o_rdata    = (i_rword >> w_shamt) & w_mask;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : MEM-stage data-memory responder with wait states   |
// | Option macro DMEM_MISALIGN_CHECK_EN faults misaligned half/word.    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module dmem_responder #(
   parameter int WORD_SIZE   = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req,
   input  logic                 i_we,
   input  logic [WORD_SIZE-1:0] i_addr,
   input  logic [1:0]           i_size,
   input  logic [WORD_SIZE-1:0] i_wdata,
   output logic                 o_ready,
   output logic                 o_ack,
   output logic [WORD_SIZE-1:0] o_rdata,
   output logic                 o_err
);
   import dmem_responder_pkg::*;

   localparam int                   c_aw    = $clog2(DEPTH_WORDS);
   localparam logic [WORD_SIZE-3:0] c_depth = (WORD_SIZE-2)'(DEPTH_WORDS);
   localparam logic [3:0]           c_wait  = 4'(WAIT_STATES);

   dmem_state_t          r_state, w_state_nxt;
   logic [3:0]           r_cnt, w_cnt_nxt;
   logic                 r_ready, r_we, r_ack, r_err;
   logic [1:0]           r_size;
   logic [WORD_SIZE-1:0] r_addr, r_wdata, r_rdata;
   logic [WORD_SIZE-1:0] r_mem [DEPTH_WORDS];

   logic                 w_accept, w_do, w_fault, w_write;
   logic [3:0]           w_be;
   logic [WORD_SIZE-1:0] w_wdata_sh, w_ld_data, w_rword;
   logic [c_aw-1:0]      w_idx;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic                 w_misalign;
`endif

   assign w_idx   = r_addr[c_aw+1:2];
   assign w_rword = r_mem[w_idx];

   dmem_lane_ctrl u_lane_ctrl (
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_wdata    (r_wdata),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wdata_sh (w_wdata_sh),
      .o_rdata    (w_ld_data),
`ifdef DMEM_MISALIGN_CHECK_EN
      .o_misalign (w_misalign)
`else
      .o_misalign ()
`endif
   );

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_fault = (r_size == SIZE_INV) | (r_addr[WORD_SIZE-1:2] >= c_depth) | w_misalign;
`else
   assign w_fault = (r_size == SIZE_INV) | (r_addr[WORD_SIZE-1:2] >= c_depth);
`endif

   assign w_write = w_do & r_we & ~w_fault;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_do        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req && r_ready) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = c_wait;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_do        = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Ready is registered so it stays low through reset and rises one edge after release.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_size  <= 2'b00;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= w_do;
         r_err   <= w_do & w_fault;
         r_rdata <= (w_do && !w_fault && !r_we) ? w_ld_data : '0;
         if (w_accept) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_size  <= i_size;
            r_wdata <= i_wdata;
         end
      end
   end

   // Array contents are deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
   end

   assign o_ready = r_ready;
   assign o_ack   = r_ack;
   assign o_err   = r_err;
   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_responder : table, sequence and random checks of the DUT    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_dmem_responder;

   localparam int WS    = 2;
   localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [31:0] i_addr = '0;
   logic [1:0]  i_size = 2'b00;
   logic [31:0] i_wdata = '0;
   logic        o_ready, o_ack, o_err;
   logic [31:0] o_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_mem [DEPTH*4];

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   dmem_responder #(
      .WORD_SIZE   (32),
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_req   (i_req),
      .i_we    (i_we),
      .i_addr  (i_addr),
      .i_size  (i_size),
      .i_wdata (i_wdata),
      .o_ready (o_ready),
      .o_ack   (o_ack),
      .o_rdata (o_rdata),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Byte-array reference: size in bytes, align down, fault rules, little-endian assembly.
   task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int nb;
      int base;
      rd = '0;
      case (size)
         2'd0:    nb = 1;
         2'd1:    nb = 2;
         2'd2:    nb = 4;
         default: nb = 0;
      endcase
      er = (nb == 0) || ((addr >> 2) >= 32'(DEPTH));
      if (!er && MIS && (addr % 32'(nb)) != 0) er = 1'b1;
      if (!er) begin
         base = int'(addr & ~(32'(nb) - 32'd1));
         for (int i = 0; i < nb; i++) begin
            if (we) m_mem[base+i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = m_mem[base+i];
         end
      end
   endtask

   // Issues one request from a negedge and returns in the ack cycle (at its negedge).
   task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int cyc, output bit rdy_ok);
      int n;
      n      = 0;
      rd     = '0;
      er     = 1'b0;
      rdy_ok = 1'b1;
      while (!o_ready && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      i_req   = 1'b1;
      i_we    = we;
      i_addr  = addr;
      i_size  = size;
      i_wdata = wd;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req   = 1'b0;
      i_we    = 1'($urandom);
      i_addr  = $urandom;
      i_size  = 2'($urandom);
      i_wdata = $urandom;
      cyc = 1;
      while (!o_ack && cyc < 40) begin
         if (o_ready) rdy_ok = 1'b0;
         @(negedge i_clk);
         cyc++;
      end
      if (!o_ack) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack after %0d cycles required ack", cyc);
      end else begin
         if (!o_ready) rdy_ok = 1'b0;
         rd = o_rdata;
         er = o_err;
      end
   endtask

   initial begin : main
      logic [31:0] rd, exp_rd, addr;
      logic        er, exp_er, we;
      logic [1:0]  sz;
      int          cyc;
      bit          rdy_ok;
      bit          ack_seen;

      tbl.push_back('{1'b1, 32'h10,  2'd2, 32'hDEADBEEF, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h10,  2'd2, 32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h10,  2'd2, 32'h11223344, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 32'h13,  2'd0, 32'hFFFFFFAA, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h10,  2'd2, 32'h0,        32'hAA223344, 1'b0});
      tbl.push_back('{1'b0, 32'h12,  2'd0, 32'h0,        32'h00000022, 1'b0});
      tbl.push_back('{1'b0, 32'h11,  2'd1, 32'h0,        MIS ? 32'h0 : 32'h00003344, MIS});
      tbl.push_back('{1'b0, 32'h12,  2'd1, 32'h0,        32'h0000AA22, 1'b0});
      tbl.push_back('{1'b1, 32'h00,  2'd2, 32'h0BADF00D, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h400, 2'd2, 32'h0,        32'h0, 1'b1});
      tbl.push_back('{1'b1, 32'h400, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 32'h00,  2'd2, 32'h0,        32'h0BADF00D, 1'b0});
      tbl.push_back('{1'b1, 32'h00,  2'd3, 32'h12345678, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 32'h00,  2'd3, 32'h0,        32'h0, 1'b1});
      tbl.push_back('{1'b0, 32'h00,  2'd2, 32'h0,        32'h0BADF00D, 1'b0});
      tbl.push_back('{1'b1, 32'h14,  2'd2, 32'h12345678, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 32'h16,  2'd1, 32'hFFFFBEEF, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h14,  2'd2, 32'h0,        32'hBEEF5678, 1'b0});
      tbl.push_back('{1'b0, 32'h15,  2'd0, 32'h0,        32'h00000056, 1'b0});
      tbl.push_back('{1'b1, 32'h18,  2'd2, 32'h00000000, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 32'h1A,  2'd2, 32'hCAFEF00D, 32'h0, MIS});
      tbl.push_back('{1'b0, 32'h18,  2'd2, 32'h0,        MIS ? 32'h0 : 32'hCAFEF00D, 1'b0});
      tbl.push_back('{1'b0, 32'h1B,  2'd2, 32'h0,        MIS ? 32'h0 : 32'hCAFEF00D, MIS});
      tbl.push_back('{1'b0, 32'hFFFFFFFC, 2'd0, 32'h0,   32'h0, 1'b1});
      tbl.push_back('{1'b1, 32'h3FC, 2'd2, 32'h01020304, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h3FF, 2'd0, 32'h0,        32'h00000001, 1'b0});

      // Reset state
      @(negedge i_clk);
      chk("rst_ready", {31'b0, o_ready}, 32'h0);
      chk("rst_ack",   {31'b0, o_ack},   32'h0);
      chk("rst_err",   {31'b0, o_err},   32'h0);
      chk("rst_rdata", o_rdata,          32'h0);
      #2 i_rst = 1'b1;
      @(negedge i_clk);
      chk("ready_after_rst", {31'b0, o_ready}, 32'h1);

      foreach (tbl[k]) begin
         access(tbl[k].we, tbl[k].addr, tbl[k].size, tbl[k].wd, rd, er, cyc, rdy_ok);
         chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp_rd);
         chk($sformatf("tbl%0d_err", k), {31'b0, er}, {31'b0, tbl[k].exp_err});
         chk($sformatf("tbl%0d_latency", k), 32'(cyc), 32'(WS + 2));
         chk($sformatf("tbl%0d_ready", k), {31'b0, rdy_ok}, 32'h1);
      end

      // Reset one cycle after a store is accepted discards it
      access(1'b1, 32'h30, 2'd2, 32'h5555AAAA, rd, er, cyc, rdy_ok);
      i_req = 1'b1; i_we = 1'b1; i_addr = 32'h30; i_size = 2'd2; i_wdata = 32'h12121212;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req = 1'b0;
      i_rst = 1'b0;
      ack_seen = 1'b0;
      #1 chk("midrst_ready", {31'b0, o_ready}, 32'h0);
      for (int c = 0; c < 8; c++) begin
         @(negedge i_clk);
         if (c == 1) i_rst = 1'b1;
         if (o_ack) ack_seen = 1'b1;
      end
      chk("midrst_no_ack", {31'b0, ack_seen}, 32'h0);
      chk("midrst_ready_back", {31'b0, o_ready}, 32'h1);
      access(1'b0, 32'h30, 2'd2, 32'h0, rd, er, cyc, rdy_ok);
      chk("midrst_old_data", rd, 32'h5555AAAA);

      // Load accepted in the store's ack cycle sees the new data
      access(1'b1, 32'h34, 2'd2, 32'h0F0F1234, rd, er, cyc, rdy_ok);
      access(1'b0, 32'h34, 2'd2, 32'h0, rd, er, cyc, rdy_ok);
      chk("raw_data", rd, 32'h0F0F1234);
      chk("raw_gap", 32'(cyc), 32'(WS + 2));
      @(negedge i_clk);
      chk("ack_one_cycle", {31'b0, o_ack}, 32'h0);

      // Randomized traffic against the byte-array model
      for (int w = 0; w < 16; w++) begin
         addr = 32'(4 * w);
         model(1'b1, addr, 2'd2, $urandom, exp_rd, exp_er);
         access(1'b1, addr, 2'd2, {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]},
                rd, er, cyc, rdy_ok);
      end
      for (int n = 0; n < 200; n++) begin
         int r;
         logic [31:0] wd;
         r  = int'($urandom_range(0, 9));
         we = 1'($urandom);
         sz = 2'($urandom);
         wd = $urandom;
         if (r == 0)      addr = 32'h400 + $urandom_range(0, 63);
         else if (r == 1) addr = 32'h8000_0000 | $urandom;
         else             addr = $urandom_range(0, 63);
         model(we, addr, sz, wd, exp_rd, exp_er);
         access(we, addr, sz, wd, rd, er, cyc, rdy_ok);
         chk("rnd_rdata", rd, exp_rd);
         chk("rnd_err", {31'b0, er}, {31'b0, exp_er});
         chk("rnd_latency", 32'(cyc), 32'(WS + 2));
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
